// File: rtl/csr_pkg.sv
// Shared definitions for the CSR unit: address map, op encodings, writable masks
// and the mcountinhibit bit layout.
package csr_pkg;

   localparam logic [11:0] CSR_FFLAGS        = 12'h001;
   localparam logic [11:0] CSR_FRM           = 12'h002;
   localparam logic [11:0] CSR_FCSR          = 12'h003;
   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;

   // Counter pages: addr[7] selects the high half, addr[4:0] the counter index.
   localparam logic [3:0] CNT_PAGE_M = 4'hB;
   localparam logic [3:0] CNT_PAGE_U = 4'hC;

   typedef enum logic [1:0] {
      OP_READ = 2'b00,
      OP_RW   = 2'b01,
      OP_RS   = 2'b10,
      OP_RC   = 2'b11
   } csr_op_e;

   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] FCSR_WMASK    = 32'h0000_00FF;
   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;

   localparam int INH_CY   = 0;
   localparam int INH_IR   = 2;
   localparam int INH_HPM0 = 3;

   function automatic logic [31:0] inhibit_wmask(int num_hpm);
      logic [31:0] m;
      m = '0;
      m[INH_CY] = 1'b1;
      m[INH_IR] = 1'b1;
      for (int i = 0; i < 29; i++)
         if (i < num_hpm) m[INH_HPM0 + i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/csr_counter.sv
// One machine counter of CNT_W bits with half-word CSR writes; a write
// replaces its half and swallows that cycle's increment.
module csr_counter #(
   parameter int CNT_W = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        inc,
   input  logic        inhibit,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [31:0] lo,
   output logic [31:0] hi
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         cnt <= '0;
      else if (wr_lo)
         cnt[31:0] <= wdata;
      else if (wr_hi)
         cnt[CNT_W-1:32] <= wdata[CNT_W-33:0];
      else if (inc && !inhibit)
         cnt <= cnt + CNT_W'(1);
   end

   assign lo = cnt[31:0];
   assign hi = 32'(cnt[CNT_W-1:32]);

endmodule

// File: rtl/csr_unit.sv
// Zicsr register file: registered read-modify-write with illegal-access
// detection, machine/hpm counters, FP flags and trap state.
module csr_unit
   import csr_pkg::*;
#(
   parameter int CNT_W   = 64,
   parameter int NUM_HPM = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   req_valid_i,
   input  logic [1:0]                             req_op_i,
   input  logic [11:0]                            req_addr_i,
   input  logic [31:0]                            req_src_i,
   input  logic                                   req_nowr_i,
   output logic                                   rsp_valid_o,
   output logic [31:0]                            rsp_rdata_o,
   output logic                                   rsp_illegal_o,
   input  logic                                   inst_retire_i,
   input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
   input  logic [4:0]                             fflags_set_i,
   input  logic                                   trap_i,
   input  logic [31:0]                            trap_cause_i,
   input  logic [31:0]                            trap_pc_i,
   input  logic                                   mret_i,
   output logic [31:0]                            mepc_o,
   output logic                                   mie_o,
   output logic [2:0]                             frm_o
);

   localparam int NCNT = 2 + NUM_HPM;
   localparam logic [31:0] INH_WMASK = inhibit_wmask(NUM_HPM);

   logic [7:0]  fcsr;
   logic [31:0] mstatus, mcountinhibit, mscratch, mepc, mcause;

   logic [NCNT-1:0]       cnt_hit, cnt_inc, cnt_inh, cnt_wr_lo, cnt_wr_hi;
   logic [NCNT-1:0][31:0] cnt_lo, cnt_hi;

   csr_op_e     op;
   logic [31:0] old, wval;
   logic        mapped, is_write, illegal, wen, cnt_page, m_page;

   assign op       = csr_op_e'(req_op_i);
   assign cnt_page = (req_addr_i[11:8] == CNT_PAGE_M || req_addr_i[11:8] == CNT_PAGE_U)
                     && req_addr_i[6:5] == 2'b00;
   assign m_page   = req_addr_i[11:8] == CNT_PAGE_M;

   // Slot 0 is cycle (index 0), slot 1 instret (index 2), then hpm3.. in order.
   for (genvar j = 0; j < NCNT; j++) begin : g_cnt
      localparam logic [4:0] IDX = (j == 0) ? 5'd0 : 5'(j + 1);
      assign cnt_hit[j]   = cnt_page && req_addr_i[4:0] == IDX;
      assign cnt_inh[j]   = mcountinhibit[IDX];
      assign cnt_wr_lo[j] = wen && m_page && cnt_hit[j] && !req_addr_i[7];
      assign cnt_wr_hi[j] = wen && m_page && cnt_hit[j] &&  req_addr_i[7];
      if (j == 0) begin : g_cy
         assign cnt_inc[j] = 1'b1;
      end else if (j == 1) begin : g_ir
         assign cnt_inc[j] = inst_retire_i;
      end else begin : g_hpm
         assign cnt_inc[j] = hpm_event_i[j-2];
      end
      csr_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .inc     (cnt_inc[j]),
         .inhibit (cnt_inh[j]),
         .wr_lo   (cnt_wr_lo[j]),
         .wr_hi   (cnt_wr_hi[j]),
         .wdata   (wval),
         .lo      (cnt_lo[j]),
         .hi      (cnt_hi[j])
      );
   end

   always_comb begin
      old    = '0;
      mapped = 1'b1;
      case (req_addr_i)
         CSR_FFLAGS:        old = {27'b0, fcsr[4:0]};
         CSR_FRM:           old = {29'b0, fcsr[7:5]};
         CSR_FCSR:          old = {24'b0, fcsr};
         CSR_MSTATUS:       old = mstatus;
         CSR_MCOUNTINHIBIT: old = mcountinhibit;
         CSR_MSCRATCH:      old = mscratch;
         CSR_MEPC:          old = mepc;
         CSR_MCAUSE:        old = mcause;
         default:           mapped = 1'b0;
      endcase
      for (int j = 0; j < NCNT; j++)
         if (cnt_hit[j]) begin
            mapped = 1'b1;
            old    = req_addr_i[7] ? cnt_hi[j] : cnt_lo[j];
         end
   end

   always_comb begin
      case (op)
         OP_RW:   wval = req_src_i;
         OP_RS:   wval = old | req_src_i;
         OP_RC:   wval = old & ~req_src_i;
         default: wval = old;
      endcase
   end

   assign is_write = op == OP_RW || ((op == OP_RS || op == OP_RC) && !req_nowr_i);
   assign illegal  = !mapped || (is_write && req_addr_i[11:10] == 2'b11);
   assign wen      = req_valid_i && is_write && !illegal;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         fcsr          <= '0;
         mstatus       <= '0;
         mcountinhibit <= '0;
         mscratch      <= '0;
         mepc          <= '0;
         mcause        <= '0;
      end else begin
         fcsr[4:0] <= fcsr[4:0] | fflags_set_i;
         if (wen) begin
            case (req_addr_i)
               CSR_FFLAGS:        fcsr[4:0] <= wval[4:0] | fflags_set_i;
               CSR_FRM:           fcsr[7:5] <= wval[2:0];
               CSR_FCSR:          fcsr <= (wval[7:0] & FCSR_WMASK[7:0]) | {3'b0, fflags_set_i};
               CSR_MSTATUS:       mstatus <= wval & MSTATUS_WMASK;
               CSR_MCOUNTINHIBIT: mcountinhibit <= wval & INH_WMASK;
               CSR_MSCRATCH:      mscratch <= wval;
               CSR_MEPC:          mepc <= wval & ~32'h3;
               CSR_MCAUSE:        mcause <= wval;
               default: ;
            endcase
         end
         // Hardware trap sequencing lands last so it overrides software writes.
         if (trap_i) begin
            mepc              <= trap_pc_i & ~32'h3;
            mcause            <= trap_cause_i;
            mstatus[MPIE_BIT] <= mstatus[MIE_BIT];
            mstatus[MIE_BIT]  <= 1'b0;
         end else if (mret_i) begin
            mstatus[MIE_BIT]  <= mstatus[MPIE_BIT];
            mstatus[MPIE_BIT] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rsp_valid_o   <= 1'b0;
         rsp_illegal_o <= 1'b0;
         rsp_rdata_o   <= '0;
      end else begin
         rsp_valid_o   <= req_valid_i;
         rsp_illegal_o <= req_valid_i && illegal;
         rsp_rdata_o   <= (req_valid_i && !illegal) ? old : '0;
      end
   end

   assign mepc_o = mepc;
   assign mie_o  = mstatus[MIE_BIT];
   assign frm_o  = fcsr[7:5];

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: a register-level reference model predicts each
// response and the visible trap/FP outputs; a negedge monitor compares them.
module tb_csr_unit;

   localparam int CNT_W   = 40;
   localparam int NUM_HPM = 4;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic [1:0]  req_op_i = '0;
   logic [11:0] req_addr_i = '0;
   logic [31:0] req_src_i = '0;
   logic        req_nowr_i = 1'b0;
   logic        rsp_valid_o, rsp_illegal_o, mie_o;
   logic [31:0] rsp_rdata_o, mepc_o;
   logic [2:0]  frm_o;
   logic        inst_retire_i = 1'b0;
   logic [NUM_HPM-1:0] hpm_event_i = '0;
   logic [4:0]  fflags_set_i = '0;
   logic        trap_i = 1'b0, mret_i = 1'b0;
   logic [31:0] trap_cause_i = '0, trap_pc_i = '0;

   csr_unit #(.CNT_W(CNT_W), .NUM_HPM(NUM_HPM)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_addr_i(req_addr_i),
      .req_src_i(req_src_i), .req_nowr_i(req_nowr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_illegal_o(rsp_illegal_o),
      .inst_retire_i(inst_retire_i), .hpm_event_i(hpm_event_i), .fflags_set_i(fflags_set_i),
      .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .mret_i(mret_i),
      .mepc_o(mepc_o), .mie_o(mie_o), .frm_o(frm_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference state, kept as architectural CSR values indexed by CSR number.
   typedef struct packed { logic ill; logic [31:0] data; } exp_t;
   exp_t        q[$];
   logic [4:0]  m_fflags;
   logic [2:0]  m_frm;
   logic        m_mie, m_mpie;
   logic [31:0] m_inh, m_scratch, m_mepc, m_mcause;
   logic [63:0] m_cnt [0:31];
   logic [63:0] cmask = (64'd1 << CNT_W) - 64'd1;

   function automatic bit present(int i);
      return i == 0 || i == 2 || (i >= 3 && i < 3 + NUM_HPM);
   endfunction

   function automatic bit event_of(int i);
      if (i == 0) return 1'b1;
      if (i == 2) return inst_retire_i;
      return hpm_event_i[i-3];
   endfunction

   function automatic void mread(input logic [11:0] a, output bit ok, output logic [31:0] v);
      ok = 1'b1;
      v  = '0;
      case (a)
         12'h001: v = 32'(m_fflags);
         12'h002: v = 32'(m_frm);
         12'h003: v = 32'({m_frm, m_fflags});
         12'h300: v = (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
         12'h320: v = m_inh;
         12'h340: v = m_scratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         default: begin
            ok = 1'b0;
            if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00 && present(int'(a[4:0]))) begin
               ok = 1'b1;
               v  = a[7] ? m_cnt[a[4:0]][63:32] : m_cnt[a[4:0]][31:0];
            end
         end
      endcase
   endfunction

   task automatic model_step();
      bit ok, wr, ill;
      logic [31:0] old, nv, inh0;
      int wi;
      exp_t e;
      inh0 = m_inh;
      wi   = -1;
      if (req_valid_i) begin
         mread(req_addr_i, ok, old);
         wr  = (req_op_i == 2'b01) || (req_op_i != 2'b00 && !req_nowr_i);
         ill = !ok || (wr && req_addr_i[11:10] == 2'b11);
         e.ill  = ill;
         e.data = ill ? 32'h0 : old;
         q.push_back(e);
         if (wr && !ill) begin
            nv = (req_op_i == 2'b01) ? req_src_i :
                 (req_op_i == 2'b10) ? (old | req_src_i) : (old & ~req_src_i);
            case (req_addr_i)
               12'h001: m_fflags = nv[4:0];
               12'h002: m_frm = nv[2:0];
               12'h003: {m_frm, m_fflags} = nv[7:0];
               12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h320: for (int i = 0; i < 32; i++) m_inh[i] = present(i) && nv[i];
               12'h340: m_scratch = nv;
               12'h341: m_mepc = {nv[31:2], 2'b00};
               12'h342: m_mcause = nv;
               default: begin
                  wi = int'(req_addr_i[4:0]);
                  if (req_addr_i[7]) m_cnt[wi][63:32] = nv;
                  else               m_cnt[wi][31:0]  = nv;
                  m_cnt[wi] = m_cnt[wi] & cmask;
               end
            endcase
         end
      end
      for (int i = 0; i < 32; i++)
         if (present(i) && i != wi && !inh0[i] && event_of(i))
            m_cnt[i] = (m_cnt[i] + 64'd1) & cmask;
      m_fflags = m_fflags | fflags_set_i;
      if (trap_i) begin
         m_mepc   = {trap_pc_i[31:2], 2'b00};
         m_mcause = trap_cause_i;
         m_mpie   = m_mie;
         m_mie    = 1'b0;
      end else if (mret_i) begin
         m_mie  = m_mpie;
         m_mpie = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_fflags = '0; m_frm = '0; m_mie = 1'b0; m_mpie = 1'b0;
      m_inh = '0; m_scratch = '0; m_mepc = '0; m_mcause = '0;
      for (int i = 0; i < 32; i++) m_cnt[i] = '0;
      q.delete();
   endtask

   always begin
      @(posedge clk or negedge reset_i);
      if (!reset_i) model_reset();
      else          model_step();
   end

   // Monitor: every pushed expectation must be answered on the very next edge.
   always begin
      exp_t e;
      @(negedge clk);
      if (reset_i) begin
         if (rsp_valid_o) begin
            if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            else begin
               e = q.pop_front();
               chk("rsp_illegal", 32'(rsp_illegal_o), 32'(e.ill));
               chk("rsp_rdata", rsp_rdata_o, e.data);
            end
         end else if (q.size() != 0) begin
            chk("missing_rsp", 32'(rsp_valid_o), 32'd1);
            q.delete();
         end
         chk("mepc_o", mepc_o, m_mepc);
         chk("mie_o", 32'(mie_o), 32'(m_mie));
         chk("frm_o", 32'(frm_o), 32'(m_frm));
      end
   end

   // Drive one request for one cycle; called at a negedge, returns at the next.
   task automatic issue(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] src, input logic nowr);
      req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_src_i = src; req_nowr_i = nowr;
      @(negedge clk);
      req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_src_i = '0; req_nowr_i = 1'b0;
   endtask

   logic [11:0] addrs [0:24] = '{12'h001, 12'h002, 12'h003, 12'h300, 12'h320, 12'h340,
      12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06,
      12'hB86, 12'hC00, 12'hC80, 12'hC02, 12'hC83, 12'hC86, 12'hB07, 12'hC01, 12'h7C0, 12'h000};

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("reset_rsp_illegal", 32'(rsp_illegal_o), 32'd0);
      chk("reset_mepc", mepc_o, 32'd0);
      reset_i = 1'b1;

      // cycle counter runs, then freezes under inhibit
      issue(2'b00, 12'hC00, 0, 0);
      issue(2'b00, 12'hC00, 0, 0);
      issue(2'b01, 12'h320, 32'h1, 0);
      issue(2'b00, 12'hC00, 0, 0);
      issue(2'b00, 12'hC00, 0, 0);
      issue(2'b01, 12'h320, 32'hFFFF_FFFF, 0);
      issue(2'b00, 12'h320, 0, 0);
      issue(2'b01, 12'h320, 32'h0, 0);

      // high-half write, truncated to CNT_W
      issue(2'b01, 12'hB80, 32'hDEAD_BEEF, 0);
      @(negedge clk);
      issue(2'b00, 12'hC80, 0, 0);
      issue(2'b00, 12'hB80, 0, 0);
      issue(2'b01, 12'hB00, 32'hFFFF_FFFE, 0);
      repeat (3) issue(2'b00, 12'hC80, 0, 0);

      // fflags accumulate alongside a same-edge CSR set
      issue(2'b01, 12'h001, 32'h1, 0);
      fflags_set_i = 5'h10;
      issue(2'b10, 12'h001, 32'h4, 0);
      fflags_set_i = 5'h00;
      issue(2'b00, 12'h003, 0, 0);
      issue(2'b01, 12'h002, 32'h5, 0);
      issue(2'b11, 12'h003, 32'h1, 0);

      // illegal accesses
      inst_retire_i = 1'b1;
      issue(2'b01, 12'hC02, 32'h5, 0);
      inst_retire_i = 1'b0;
      issue(2'b10, 12'hC02, 32'h0, 1);
      issue(2'b00, 12'h7C0, 0, 0);
      issue(2'b00, 12'hC01, 0, 0);
      issue(2'b11, 12'hC00, 32'h3, 0);
      issue(2'b00, 12'hB07, 0, 0);

      // trap entry and mret
      issue(2'b01, 12'h300, 32'h8, 0);
      trap_i = 1'b1; trap_cause_i = 32'hB; trap_pc_i = 32'h1003;
      @(negedge clk);
      trap_i = 1'b0;
      issue(2'b00, 12'h341, 0, 0);
      issue(2'b00, 12'h342, 0, 0);
      issue(2'b00, 12'h300, 0, 0);
      mret_i = 1'b1;
      @(negedge clk);
      mret_i = 1'b0;
      issue(2'b00, 12'h300, 0, 0);

      // trap beats a same-cycle mepc write
      trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h2468;
      issue(2'b01, 12'h341, 32'h2000, 0);
      trap_i = 1'b0;
      issue(2'b00, 12'h341, 0, 0);

      // reset while a response is pending
      req_valid_i = 1'b1; req_op_i = 2'b00; req_addr_i = 12'h340;
      @(posedge clk);
      #1 reset_i = 1'b0;
      req_valid_i = 1'b0; req_addr_i = '0;
      @(negedge clk);
      chk("reset_drops_rsp", 32'(rsp_valid_o), 32'd0);
      reset_i = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 32'(rsp_valid_o), 32'd0);

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         inst_retire_i = 1'($urandom_range(0, 1));
         hpm_event_i   = NUM_HPM'($urandom);
         fflags_set_i  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'h0;
         trap_i        = $urandom_range(0, 19) == 0;
         trap_cause_i  = $urandom;
         trap_pc_i     = $urandom;
         req_valid_i   = $urandom_range(0, 2) != 0;
         mret_i        = !req_valid_i && $urandom_range(0, 9) == 0;
         req_op_i      = 2'($urandom);
         req_addr_i    = addrs[$urandom_range(0, 24)];
         req_src_i     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         req_nowr_i    = $urandom_range(0, 3) == 0;
         @(negedge clk);
      end
      req_valid_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
      inst_retire_i = 1'b0; hpm_event_i = '0; fflags_set_i = '0;
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
